// File: rtl/mult_share_arbiter_taint.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier between two
// clients, with taint tracking on every control output and data word.
module mult_share_arbiter_taint #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               req0_t,
  input  logic               req1_t,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               a0_t,
  input  logic               b0_t,
  input  logic               a1_t,
  input  logic               b1_t,
  output logic               mult_start,
  output logic               mult_start_t,
  output logic [WIDTH-1:0]   mult_md,
  output logic [WIDTH-1:0]   mult_mr,
  output logic               mult_md_t,
  output logic               mult_mr_t,
  input  logic               mult_done,
  input  logic               mult_done_t,
  input  logic [2*WIDTH-1:0] mult_product,
  input  logic               mult_product_t,
  output logic               done0,
  output logic               done1,
  output logic               done0_t,
  output logic               done1_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               busy,
  output logic               busy_t
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic               owner_r;
  logic               last_r;
  logic               ctrl_t_r;
  logic [WIDTH-1:0]   md_r;
  logic [WIDTH-1:0]   mr_r;
  logic               md_t_r;
  logic               mr_t_r;
  logic [2*WIDTH-1:0] product_r;
  logic               product_t_r;

  logic               any_req_s;
  logic               req_t_s;
  logic               win_s;
  logic [WIDTH-1:0]   win_a_s;
  logic [WIDTH-1:0]   win_b_s;
  logic               win_a_t_s;
  logic               win_b_t_s;

  // Under contention the client that was not served last wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic lst);
    return r1 & (~r0 | ~lst);
  endfunction

  assign any_req_s = req0 | req1;
  assign req_t_s   = req0_t | req1_t;
  assign win_s     = pick_winner(req0, req1, last_r);
  assign win_a_s   = win_s ? a1 : a0;
  assign win_b_s   = win_s ? b1 : b0;
  assign win_a_t_s = win_s ? a1_t : a0_t;
  assign win_b_t_s = win_s ? b1_t : b0_t;

  // Next-state decode for the IDLE/ISSUE/WAIT/RESP job sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (mult_done) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant, operand/product latches and taint registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      ctrl_t_r    <= 1'b0;
      md_r        <= '0;
      mr_r        <= '0;
      md_t_r      <= 1'b0;
      mr_t_r      <= 1'b0;
      product_r   <= '0;
      product_t_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          // Request taint is tracked even with no request, so a missing grant is tainted too.
          ctrl_t_r <= req_t_s;
          if (any_req_s) begin
            owner_r <= win_s;
            md_r    <= win_a_s;
            mr_r    <= win_b_s;
            md_t_r  <= win_a_t_s | req_t_s;
            mr_t_r  <= win_b_t_s | req_t_s;
          end
        end
        WAIT: begin
          ctrl_t_r <= ctrl_t_r | mult_done_t;
          if (mult_done) begin
            product_r   <= mult_product;
            product_t_r <= mult_product_t | ctrl_t_r | mult_done_t;
          end
        end
        RESP: last_r <= owner_r;
        default: begin
        end
      endcase
    end
  end

  assign mult_start   = (state_r == ISSUE);
  assign busy         = (state_r != IDLE);
  assign done0        = (state_r == RESP) & ~owner_r;
  assign done1        = (state_r == RESP) & owner_r;
  assign mult_start_t = ctrl_t_r;
  assign busy_t       = ctrl_t_r;
  assign done0_t      = ctrl_t_r;
  assign done1_t      = ctrl_t_r;
  assign mult_md      = md_r;
  assign mult_mr      = mr_r;
  assign mult_md_t    = md_t_r;
  assign mult_mr_t    = mr_t_r;
  assign product      = product_r;
  assign product_t    = product_t_r;

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// Table-driven bench for mult_share_arbiter_taint with a scoreboard of
// expected job completions and a cycle-accurate multiplier model.
module tb_mult_share_arbiter_taint;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, req0_t, req1_t;
  logic [3:0] a0, b0, a1, b1;
  logic       a0_t, b0_t, a1_t, b1_t;
  logic       mult_start, mult_start_t;
  logic [3:0] mult_md, mult_mr;
  logic       mult_md_t, mult_mr_t;
  logic       mult_done, mult_done_t;
  logic [7:0] mult_product;
  logic       mult_product_t;
  logic       done0, done1, done0_t, done1_t;
  logic [7:0] product;
  logic       product_t, busy, busy_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_done = 0;

  // tnt bits: [7]=req0_t [6]=req1_t [5]=a0_t [4]=b0_t [3]=a1_t [2]=b1_t [1]=product_t [0]=done_t
  typedef struct {
    logic       r0, r1;
    logic [3:0] a0, b0, a1, b1;
    logic [7:0] tnt;
    int         d;
    logic       own;
    logic [7:0] prod;
    logic       pre_rst, gap, clean;
  } vec_t;

  typedef struct {
    logic       own;
    logic [7:0] prod;
    logic       prod_t, done_t, gap;
    int         d, t0;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];

  mult_share_arbiter_taint #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req0_t(req0_t), .req1_t(req1_t),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .a0_t(a0_t), .b0_t(b0_t), .a1_t(a1_t), .b1_t(b1_t),
    .mult_start(mult_start), .mult_start_t(mult_start_t),
    .mult_md(mult_md), .mult_mr(mult_mr),
    .mult_md_t(mult_md_t), .mult_mr_t(mult_mr_t),
    .mult_done(mult_done), .mult_done_t(mult_done_t),
    .mult_product(mult_product), .mult_product_t(mult_product_t),
    .done0(done0), .done1(done1), .done0_t(done0_t), .done1_t(done1_t),
    .product(product), .product_t(product_t),
    .busy(busy), .busy_t(busy_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_taints();
    req0_t = 1'b0; req1_t = 1'b0;
    a0_t = 1'b0; b0_t = 1'b0; a1_t = 1'b0; b1_t = 1'b0;
  endtask

  // Drive one job from an IDLE negedge through its done strobe and the following IDLE cycle.
  task automatic run_job(input vec_t v);
    exp_t e;
    exp_t g;
    logic req_t, md_t, mr_t;
    logic got;
    if (v.pre_rst) apply_reset();
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    req0_t = v.tnt[7]; req1_t = v.tnt[6];
    a0_t = v.tnt[5]; b0_t = v.tnt[4]; a1_t = v.tnt[3]; b1_t = v.tnt[2];
    req_t    = v.tnt[7] | v.tnt[6];
    md_t     = (v.own ? v.tnt[3] : v.tnt[5]) | req_t;
    mr_t     = (v.own ? v.tnt[2] : v.tnt[4]) | req_t;
    e.own    = v.own;
    e.prod   = v.prod;
    e.prod_t = v.tnt[1] | req_t | v.tnt[0];
    e.done_t = req_t | v.tnt[0];
    e.gap    = v.gap;
    e.d      = v.d;
    e.t0     = cyc;
    exp_q.push_back(e);

    step();
    chk("issue_start", mult_start, 1);
    chk("issue_busy", busy, 1);
    chk("issue_md", mult_md, v.own ? v.a1 : v.a0);
    chk("issue_mr", mult_mr, v.own ? v.b1 : v.b0);
    chk("issue_taints", {mult_start_t, busy_t, mult_md_t, mult_mr_t}, {req_t, req_t, md_t, mr_t});

    for (int w = 1; w <= v.d; w++) begin
      step();
      if (w == 1) chk("wait_start_low", {mult_start, done0, done1}, 0);
      if (w == v.d) begin
        mult_done      = 1'b1;
        mult_product   = {4'd0, mult_md} * {4'd0, mult_mr};
        mult_product_t = v.tnt[1];
        mult_done_t    = v.tnt[0];
      end
    end
    step();
    mult_done = 1'b0; mult_done_t = 1'b0; mult_product_t = 1'b0; mult_product = 8'd0;

    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      if (done0 | done1) got = 1'b1;
      else step();
    end
    if (!got || exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done strobe expected one within budget");
    end else begin
      g = exp_q.pop_front();
      chk("done_owner", {done1, done0}, g.own ? 2'b10 : 2'b01);
      chk("product", product, g.prod);
      chk("product_t", product_t, g.prod_t);
      chk("done_t", {done0_t, done1_t}, {g.done_t, g.done_t});
      chk("latency", cyc - g.t0, g.d + 2);
      if (g.gap) chk("done_spacing", cyc - prev_done, g.d + 3);
      prev_done = cyc;
    end
    if (v.own) req1 = 1'b0;
    else req0 = 1'b0;
    clear_taints();

    step();
    chk("idle_after_done", {busy, mult_start, done0, done1}, 0);
    if (v.clean) begin
      step();
      chk("clean_idle_taints", {mult_start_t, busy_t, done0_t, done1_t}, 0);
      chk("no_regrant", busy, 0);
    end
  endtask

  initial begin
    vec_t v;
    // r0 r1 a0 b0 a1 b1 tnt d own prod pre_rst gap clean
    vecs[0] = '{1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 8'h00, 4, 1'b0, 8'd15, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'd2, 4'd7, 4'd2, 4'd7, 8'h00, 3, 1'b0, 8'd14, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'd2, 4'd7, 4'd2, 4'd7, 8'h00, 3, 1'b1, 8'd14, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd2, 4'd7, 4'd2, 4'd7, 8'h00, 3, 1'b0, 8'd14, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'd2, 4'd7, 4'd2, 4'd7, 8'h00, 3, 1'b1, 8'd14, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 8'h40, 2, 1'b0, 8'd1,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'd6, 4'd9, 4'd0, 4'd0, 8'h10, 2, 1'b0, 8'd54, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 4'd4, 8'h02, 3, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 4'd5, 4'd3, 4'd0, 4'd0, 8'h01, 2, 1'b0, 8'd15, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd8, 8'h00, 1, 1'b1, 8'd56, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    clear_taints();
    mult_done = 1'b0; mult_done_t = 1'b0; mult_product = 8'd0; mult_product_t = 1'b0;
    step();
    step();
    chk("reset_outputs", {busy, mult_start, done0, done1, mult_md, mult_mr, product}, 0);
    chk("reset_taints", {mult_start_t, busy_t, done0_t, done1_t, mult_md_t, mult_mr_t, product_t}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_job(vecs[i]);

    // Abort a tainted job in WAIT; nothing of it may survive.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd9; a0_t = 1'b1; req1_t = 1'b1;
    step();
    step();
    chk("midwait_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; req0 = 1'b0;
    clear_taints();
    chk("rst_mid_outputs", {busy, mult_start, done0, done1, mult_md, mult_mr, product}, 0);
    chk("rst_mid_taints", {mult_start_t, busy_t, done0_t, done1_t, mult_md_t, mult_mr_t, product_t}, 0);
    mult_done = 1'b1; mult_product = 8'hAA;
    step();
    mult_done = 1'b0; mult_product = 8'd0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_done_ignored", {busy, done0, done1, product}, 0);
      step();
    end
    v = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 8'h00, 2, 1'b1, 8'd225, 1'b0, 1'b0, 1'b0};
    run_job(v);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
